// File: rtl/r4_butterfly_pipe.sv
// r4_butterfly_pipe: two-stage valid/ready radix-4 complex butterfly (forward/inverse per beat).
// Define R4_SCALE_EN to divide every output by 4 with round-half-up; undefined gives full precision.
module r4_butterfly_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned TAG_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_inverse,
  input  logic [TAG_W-1:0]        in_tag,
  input  logic signed [WIDTH-1:0] x0r,
  input  logic signed [WIDTH-1:0] x0i,
  input  logic signed [WIDTH-1:0] x1r,
  input  logic signed [WIDTH-1:0] x1i,
  input  logic signed [WIDTH-1:0] x2r,
  input  logic signed [WIDTH-1:0] x2i,
  input  logic signed [WIDTH-1:0] x3r,
  input  logic signed [WIDTH-1:0] x3i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [TAG_W-1:0]        out_tag,
  output logic signed [WIDTH+1:0] y0r,
  output logic signed [WIDTH+1:0] y0i,
  output logic signed [WIDTH+1:0] y1r,
  output logic signed [WIDTH+1:0] y1i,
  output logic signed [WIDTH+1:0] y2r,
  output logic signed [WIDTH+1:0] y2i,
  output logic signed [WIDTH+1:0] y3r,
  output logic signed [WIDTH+1:0] y3i
);
  localparam int unsigned W1 = WIDTH + 1;
  localparam int unsigned W2 = WIDTH + 2;
  localparam int unsigned W3 = WIDTH + 3;

  function automatic logic signed [W1-1:0] sx1(input logic signed [WIDTH-1:0] v);
    return W1'(v);
  endfunction

  function automatic logic signed [W2-1:0] sx2(input logic signed [W1-1:0] v);
    return W2'(v);
  endfunction

  function automatic logic signed [W2-1:0] scl(input logic signed [W2-1:0] v);
`ifdef R4_SCALE_EN
    logic signed [W3-1:0] t;
    t = W3'(v) + W3'(2);
    return W2'(t >>> 2);
`else
    return v;
`endif
  endfunction

  logic w_s1_en, w_s2_en;

  logic                 r_s1_valid, r_s1_inv;
  logic [TAG_W-1:0]     r_s1_tag;
  logic signed [W1-1:0] r_ar, r_ai, r_br, r_bi, r_cr, r_ci, r_dr, r_di;

  logic                 r_out_valid;
  logic [TAG_W-1:0]     r_out_tag;
  logic signed [W2-1:0] r_y0r, r_y0i, r_y1r, r_y1i, r_y2r, r_y2i, r_y3r, r_y3i;
  logic signed [W2-1:0] w_y0r, w_y0i, w_y1r, w_y1i, w_y2r, w_y2i, w_y3r, w_y3i;

  // Each stage advances when its successor is empty or draining this cycle.
  assign w_s2_en  = !r_out_valid || out_ready;
  assign w_s1_en  = !r_s1_valid || w_s2_en;
  assign in_ready = w_s1_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_inv   <= 1'b0;
      r_s1_tag   <= '0;
      r_ar <= '0; r_ai <= '0; r_br <= '0; r_bi <= '0;
      r_cr <= '0; r_ci <= '0; r_dr <= '0; r_di <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_inv <= in_inverse;
        r_s1_tag <= in_tag;
        r_ar <= sx1(x0r) + sx1(x2r);
        r_ai <= sx1(x0i) + sx1(x2i);
        r_br <= sx1(x0r) - sx1(x2r);
        r_bi <= sx1(x0i) - sx1(x2i);
        r_cr <= sx1(x1r) + sx1(x3r);
        r_ci <= sx1(x1i) + sx1(x3i);
        r_dr <= sx1(x1r) - sx1(x3r);
        r_di <= sx1(x1i) - sx1(x3i);
      end
    end
  end

  // Inverse direction rotates d by +j instead of -j, which swaps the Y1/Y3 formulas.
  always_comb begin
    w_y0r = sx2(r_ar) + sx2(r_cr);
    w_y0i = sx2(r_ai) + sx2(r_ci);
    w_y2r = sx2(r_ar) - sx2(r_cr);
    w_y2i = sx2(r_ai) - sx2(r_ci);
    w_y1r = sx2(r_br) + sx2(r_di);
    w_y1i = sx2(r_bi) - sx2(r_dr);
    w_y3r = sx2(r_br) - sx2(r_di);
    w_y3i = sx2(r_bi) + sx2(r_dr);
    if (r_s1_inv) begin
      w_y1r = sx2(r_br) - sx2(r_di);
      w_y1i = sx2(r_bi) + sx2(r_dr);
      w_y3r = sx2(r_br) + sx2(r_di);
      w_y3i = sx2(r_bi) - sx2(r_dr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_tag   <= '0;
      r_y0r <= '0; r_y0i <= '0; r_y1r <= '0; r_y1i <= '0;
      r_y2r <= '0; r_y2i <= '0; r_y3r <= '0; r_y3i <= '0;
    end else if (w_s2_en) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_tag <= r_s1_tag;
        r_y0r <= scl(w_y0r); r_y0i <= scl(w_y0i);
        r_y1r <= scl(w_y1r); r_y1i <= scl(w_y1i);
        r_y2r <= scl(w_y2r); r_y2i <= scl(w_y2i);
        r_y3r <= scl(w_y3r); r_y3i <= scl(w_y3i);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_tag   = r_out_tag;
  assign y0r = r_y0r;
  assign y0i = r_y0i;
  assign y1r = r_y1r;
  assign y1i = r_y1i;
  assign y2r = r_y2r;
  assign y2i = r_y2i;
  assign y3r = r_y3r;
  assign y3i = r_y3i;

endmodule

// File: tb/tb_r4_butterfly_pipe.sv
// Bench for r4_butterfly_pipe: vector table, backpressure, throughput and reset sequences,
// with a DFT-based scoreboard checking every output beat.
module tb_r4_butterfly_pipe;
  localparam int W  = 16;
  localparam int TW = 4;

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready, in_inverse, out_valid, out_ready;
  logic [TW-1:0] in_tag, out_tag;
  logic signed [W-1:0] x0r, x0i, x1r, x1i, x2r, x2i, x3r, x3i;
  logic signed [W+1:0] y0r, y0i, y1r, y1i, y2r, y2i, y3r, y3i;

  always #5 clk = ~clk;

  r4_butterfly_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inverse(in_inverse), .in_tag(in_tag),
    .x0r(x0r), .x0i(x0i), .x1r(x1r), .x1i(x1i),
    .x2r(x2r), .x2i(x2i), .x3r(x3r), .x3i(x3i),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .y0r(y0r), .y0i(y0i), .y1r(y1r), .y1i(y1i),
    .y2r(y2r), .y2i(y2i), .y3r(y3r), .y3i(y3i)
  );

  typedef struct {
    int          yr[4];
    int          yi[4];
    logic [TW-1:0] tag;
  } exp_t;

  typedef struct {
    int          xr[4];
    int          xi[4];
    bit          inv;
    logic [TW-1:0] tag;
    int          yr[4];
    int          yi[4];
  } vec_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  exp_t sb[$];
  int log_tag[$];
  int log_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sc(input int v);
`ifdef R4_SCALE_EN
    return (v + 2) >>> 2;
`else
    return v;
`endif
  endfunction

  // Reference: Yk = sum_n Xn * w^(n*k), w = -j (forward) or +j (inverse).
  function automatic exp_t model(input int xr[4], input int xi[4], input bit inv,
                                 input logic [TW-1:0] tag);
    exp_t e;
    int m, r, i;
    e.tag = tag;
    for (int k = 0; k < 4; k++) begin
      e.yr[k] = 0;
      e.yi[k] = 0;
      for (int n = 0; n < 4; n++) begin
        m = inv ? ((n * k) % 4) : ((3 * n * k) % 4);
        case (m)
          0:       begin r =  xr[n]; i =  xi[n]; end
          1:       begin r = -xi[n]; i =  xr[n]; end
          2:       begin r = -xr[n]; i = -xi[n]; end
          default: begin r =  xi[n]; i = -xr[n]; end
        endcase
        e.yr[k] += r;
        e.yi[k] += i;
      end
      e.yr[k] = sc(e.yr[k]);
      e.yi[k] = sc(e.yi[k]);
    end
    return e;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic get_y(output int yr[4], output int yi[4]);
    yr[0] = int'(y0r); yi[0] = int'(y0i);
    yr[1] = int'(y1r); yi[1] = int'(y1i);
    yr[2] = int'(y2r); yi[2] = int'(y2i);
    yr[3] = int'(y3r); yi[3] = int'(y3i);
  endtask

  task automatic get_x(output int xr[4], output int xi[4]);
    xr[0] = int'(x0r); xi[0] = int'(x0i);
    xr[1] = int'(x1r); xi[1] = int'(x1i);
    xr[2] = int'(x2r); xi[2] = int'(x2i);
    xr[3] = int'(x3r); xi[3] = int'(x3i);
  endtask

  task automatic put(input int xr[4], input int xi[4], input bit inv, input int tag);
    x0r = xr[0][W-1:0]; x0i = xi[0][W-1:0];
    x1r = xr[1][W-1:0]; x1i = xi[1][W-1:0];
    x2r = xr[2][W-1:0]; x2i = xi[2][W-1:0];
    x3r = xr[3][W-1:0]; x3i = xi[3][W-1:0];
    in_inverse = inv;
    in_tag     = tag[TW-1:0];
    in_valid   = 1'b1;
  endtask

  task automatic rand_beat(output int xr[4], output int xi[4]);
    for (int n = 0; n < 4; n++) begin
      xr[n] = int'($urandom_range(65535, 0)) - 32768;
      xi[n] = int'($urandom_range(65535, 0)) - 32768;
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: inputs and outputs sampled mid-cycle, ahead of the edge that transfers them.
  always @(negedge clk) begin : monitor
    int ar[4], ai[4];
    exp_t e;
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        log_tag.push_back(int'(out_tag));
        log_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          get_y(ar, ai);
          chk("sb_tag", int'(out_tag), int'(e.tag));
          for (int k = 0; k < 4; k++) begin
            chk($sformatf("sb_y%0dr", k), ar[k], e.yr[k]);
            chk($sformatf("sb_y%0di", k), ai[k], e.yi[k]);
          end
        end
      end
      if (in_valid && in_ready) begin
        get_x(ar, ai);
        sb.push_back(model(ar, ai, in_inverse, in_tag));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    chk("watchdog_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  vec_t vt[7];
  int   cx_r[4], cx_i[4], yr[4], yi[4], sn_r[4], sn_i[4];
  int   idx, nacc;

  initial begin
    vt[0] = '{'{0, 1, 2, 3}, '{0, 0, 0, 0}, 1'b0, 4'h1, '{6, -2, -2, -2}, '{0, 2, 0, -2}};
    vt[1] = '{'{0, 1, 2, 3}, '{0, 0, 0, 0}, 1'b1, 4'h2, '{6, -2, -2, -2}, '{0, -2, 0, 2}};
    vt[2] = '{'{-32768, -32768, -32768, -32768}, '{0, 0, 0, 0}, 1'b0, 4'h3,
              '{-131072, 0, 0, 0}, '{0, 0, 0, 0}};
    vt[3] = '{'{32767, 32767, 32767, 32767}, '{0, 0, 0, 0}, 1'b0, 4'h4,
              '{131068, 0, 0, 0}, '{0, 0, 0, 0}};
    vt[4] = '{'{0, 0, 0, 0}, '{0, 5, 0, 0}, 1'b0, 4'h5, '{0, 5, 0, -5}, '{5, 0, -5, 0}};
    vt[5] = '{'{0, 0, 0, 0}, '{0, 5, 0, 0}, 1'b1, 4'h6, '{0, -5, 0, 5}, '{5, 0, -5, 0}};
    vt[6] = '{'{-32768, -32768, -32768, -32768}, '{-32768, -32768, -32768, -32768}, 1'b1, 4'hF,
              '{-131072, 0, 0, 0}, '{-131072, 0, 0, 0}};

    reset = 1'b1; in_valid = 1'b0; in_inverse = 1'b0; in_tag = '0; out_ready = 1'b1;
    x0r = '0; x0i = '0; x1r = '0; x1i = '0; x2r = '0; x2i = '0; x3r = '0; x3i = '0;
    repeat (2) tick;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_tag", int'(out_tag), 0);
    get_y(yr, yi);
    for (int k = 0; k < 4; k++) begin
      chk("rst_yr", yr[k], 0);
      chk("rst_yi", yi[k], 0);
    end
    reset = 1'b0;
    chk("rst_in_ready", int'(in_ready), 1);

    // Vector table: each beat alone, checking the 2-cycle latency and exact outputs.
    for (int t = 0; t < 7; t++) begin
      put(vt[t].xr, vt[t].xi, vt[t].inv, int'(vt[t].tag));
      chk("tv_in_ready", int'(in_ready), 1);
      tick;
      in_valid = 1'b0;
      chk("tv_lat1_valid", int'(out_valid), 0);
      tick;
      chk("tv_out_valid", int'(out_valid), 1);
      chk("tv_out_tag", int'(out_tag), int'(vt[t].tag));
      get_y(yr, yi);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("tv%0d_y%0dr", t, k), yr[k], sc(vt[t].yr[k]));
        chk($sformatf("tv%0d_y%0di", t, k), yi[k], sc(vt[t].yi[k]));
      end
      tick;
    end

    // Backpressure: five tagged beats offered against a stalled sink.
    out_ready = 1'b0; idx = 1; nacc = 0;
    rand_beat(cx_r, cx_i);
    for (int c = 0; c < 6; c++) begin
      put(cx_r, cx_i, 1'b0, idx);
      @(negedge clk);
      if (in_ready) begin
        nacc++; idx++;
        rand_beat(cx_r, cx_i);
      end
      tick;
    end
    chk("bp_accepted", nacc, 2);
    chk("bp_in_ready", int'(in_ready), 0);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_out_tag", int'(out_tag), 1);
    get_y(sn_r, sn_i);
    repeat (3) tick;
    chk("bp_hold_valid", int'(out_valid), 1);
    chk("bp_hold_tag", int'(out_tag), 1);
    get_y(yr, yi);
    for (int k = 0; k < 4; k++) begin
      chk("bp_hold_yr", yr[k], sn_r[k]);
      chk("bp_hold_yi", yi[k], sn_i[k]);
    end
    log_tag.delete(); log_cyc.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx <= 5; c++) begin
      put(cx_r, cx_i, 1'b0, idx);
      @(negedge clk);
      if (in_ready) begin
        idx++;
        rand_beat(cx_r, cx_i);
      end
      tick;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && log_tag.size() < 5; c++) tick;
    chk("bp_count", log_tag.size(), 5);
    for (int k = 0; k < log_tag.size() && k < 5; k++) chk("bp_order", log_tag[k], k + 1);
    for (int k = 1; k < log_cyc.size(); k++) chk("bp_consec", log_cyc[k] - log_cyc[k-1], 1);

    // Throughput: 100 random back-to-back beats with an always-ready sink.
    log_tag.delete(); log_cyc.delete();
    for (int c = 0; c < 100; c++) begin
      rand_beat(cx_r, cx_i);
      put(cx_r, cx_i, 1'($urandom_range(1, 0)), c % 16);
      @(negedge clk);
      chk("tp_in_ready", int'(in_ready), 1);
      tick;
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && log_tag.size() < 100; c++) tick;
    chk("tp_count", log_tag.size(), 100);
    for (int k = 1; k < log_cyc.size(); k++) chk("tp_consec", log_cyc[k] - log_cyc[k-1], 1);

    // Reset with two beats in flight: neither may ever appear.
    log_tag.delete(); log_cyc.delete();
    rand_beat(cx_r, cx_i);
    put(cx_r, cx_i, 1'b0, 7);
    tick;
    rand_beat(cx_r, cx_i);
    put(cx_r, cx_i, 1'b1, 8);
    tick;
    reset = 1'b1; in_valid = 1'b0;
    tick;
    chk("rmid_out_valid", int'(out_valid), 0);
    chk("rmid_out_tag", int'(out_tag), 0);
    get_y(yr, yi);
    for (int k = 0; k < 4; k++) begin
      chk("rmid_yr", yr[k], 0);
      chk("rmid_yi", yi[k], 0);
    end
    reset = 1'b0;
    chk("rmid_in_ready", int'(in_ready), 1);
    repeat (6) tick;
    chk("rmid_no_ghost", log_tag.size(), 0);
    chk("rmid_out_valid_after", int'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
